sram_bridge_2x1: RTL and testbench

SRAM_BRIDGE_2X1 -- requirements
Module: sram_bridge_2x1

---
 rtl/sram_bridge_2x1.sv | 105 ++++++++++
 tb/tb_sram_bridge_2x1.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bridge_2x1.sv
// Two-into-one SRAM-like bridge: the instruction and data requesters share one master port.
// Only one transaction is in flight at a time, and ties between the two sides are settled round-robin.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | no transaction owned; arbitrate and forward request
// WAIT_I | inst transaction accepted, waiting for m_data_ok
// WAIT_D | data transaction accepted, waiting for m_data_ok
module sram_bridge_2x1 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [DATA_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [DATA_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,

   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [DATA_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_I = 2'd1,
      WAIT_D = 2'd2
   } state_t;

   state_t state;
   logic   last_data;
   logic   any_req;
   logic   sel_data;
   logic   fwd_req;

   assign any_req  = inst_req | data_req;
   // On a tie, the side that did not win the last grant is selected.
   assign sel_data = data_req & (~inst_req | ~last_data);
   // Gating with rst keeps the master port quiet while reset is held low.
   assign fwd_req  = rst & (state == IDLE) & any_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last_data <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req && m_addr_ok) begin
                  state     <= sel_data ? WAIT_D : WAIT_I;
                  last_data <= sel_data;
               end
            end
            WAIT_I, WAIT_D: begin
               if (m_data_ok) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      m_req        = 1'b0;
      m_wr         = 1'b0;
      m_size       = 2'd0;
      m_addr       = '0;
      m_wdata      = '0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      if (fwd_req) begin
         m_req        = 1'b1;
         m_wr         = sel_data ? data_wr    : inst_wr;
         m_size       = sel_data ? data_size  : inst_size;
         m_addr       = sel_data ? data_addr  : inst_addr;
         m_wdata      = sel_data ? data_wdata : inst_wdata;
         inst_addr_ok = m_addr_ok & ~sel_data;
         data_addr_ok = m_addr_ok & sel_data;
      end
   end

   assign inst_data_ok = rst & (state == WAIT_I) & m_data_ok;
   assign data_data_ok = rst & (state == WAIT_D) & m_data_ok;
   assign inst_rdata   = m_rdata;
   assign data_rdata   = m_rdata;

endmodule

// File: tb/tb_sram_bridge_2x1.sv
// Bench for sram_bridge_2x1: directed scenarios followed by random traffic.
// Every cycle is checked against a transaction-level ownership model.
module tb_sram_bridge_2x1;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic         inst_req, inst_wr, inst_addr_ok, inst_data_ok;
   logic [1:0]   inst_size;
   logic [W-1:0] inst_addr, inst_wdata, inst_rdata;
   logic         data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]   data_size;
   logic [W-1:0] data_addr, data_wdata, data_rdata;
   logic         m_req, m_wr, m_addr_ok, m_data_ok;
   logic [1:0]   m_size;
   logic [W-1:0] m_addr, m_wdata, m_rdata;

   sram_bridge_2x1 #(.DATA_W(W)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
      .m_data_ok(m_data_ok)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int owner    = 0;     // 0 none, 1 inst, 2 data
   bit last_data = 1'b0; // side that won the most recent grant
   int           g_cyc[$];
   logic [W-1:0] g_addr[$];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit pick_data();
      return data_req && (!inst_req || !last_data);
   endfunction

   task automatic clr();
      inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
      m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
   endtask

   task automatic model_reset();
      owner = 0;
      last_data = 1'b0;
   endtask

   // Compare every output against the model, at the falling edge.
   task automatic sample();
      bit pend, sd;
      @(negedge clk);
      pend = rst && owner == 0 && (inst_req || data_req);
      sd   = pick_data();
      chk("m_req", m_req, pend);
      chk("inst_addr_ok", inst_addr_ok, pend && !sd && m_addr_ok);
      chk("data_addr_ok", data_addr_ok, pend && sd && m_addr_ok);
      chk("inst_data_ok", inst_data_ok, rst && owner == 1 && m_data_ok);
      chk("data_data_ok", data_data_ok, rst && owner == 2 && m_data_ok);
      chk("inst_rdata", inst_rdata, m_rdata);
      chk("data_rdata", data_rdata, m_rdata);
      if (pend) begin
         chk("m_wr", m_wr, sd ? data_wr : inst_wr);
         chk("m_size", m_size, sd ? data_size : inst_size);
         chk("m_addr", m_addr, sd ? data_addr : inst_addr);
         chk("m_wdata", m_wdata, sd ? data_wdata : inst_wdata);
      end else if (rst && owner != 0) begin
         chk("wait_ctl", {m_wr, m_size}, 0);
         chk("wait_addr", m_addr, 0);
         chk("wait_wdata", m_wdata, 0);
      end
      if (m_req && m_addr_ok) begin
         g_cyc.push_back(cyc);
         g_addr.push_back(m_addr);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         if (owner == 0) begin
            if ((inst_req || data_req) && m_addr_ok) begin
               owner = pick_data() ? 2 : 1;
               last_data = (owner == 2);
            end
         end else if (m_data_ok) begin
            owner = 0;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   task automatic finish_txn();
      clr();
      m_data_ok = 1;
      step();
      clr();
   endtask

   initial begin
      clr();
      rst = 0;
      model_reset();
      // Reset holds outputs low whatever the inputs are doing.
      inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
      sample();
      chk("rst_m_req", m_req, 0);
      advance();
      step();
      clr();
      rst = 1;

      // Lone inst read
      inst_req = 1; inst_addr = 32'hBFC00000; m_addr_ok = 1;
      sample();
      chk("lone_addr", m_addr, 32'hBFC00000);
      chk("lone_addr_ok", inst_addr_ok, 1);
      advance();
      clr();
      step();
      m_data_ok = 1; m_rdata = 32'h24080001;
      sample();
      chk("lone_data_ok", inst_data_ok, 1);
      chk("lone_rdata", inst_rdata, 32'h24080001);
      chk("lone_d_data_ok", data_data_ok, 0);
      advance();
      clr();

      // Tie after reset, slave always ready
      rst = 0; model_reset();
      step();
      rst = 1;
      g_cyc.delete(); g_addr.delete();
      inst_req = 1; inst_addr = 32'h100;
      data_req = 1; data_addr = 32'h200;
      m_addr_ok = 1; m_data_ok = 1;
      repeat (5) step();
      chk("rr_count", W'(g_addr.size()), 3);
      if (g_addr.size() >= 3) begin
         chk("rr_g0", g_addr[0], 32'h200);
         chk("rr_g1", g_addr[1], 32'h100);
         chk("rr_g2", g_addr[2], 32'h200);
         chk("rr_gap1", W'(g_cyc[1] - g_cyc[0]), 2);
         chk("rr_gap2", W'(g_cyc[2] - g_cyc[1]), 2);
      end
      finish_txn();

      // Back-pressure on a data write
      data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h3000;
      data_wdata = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("bp_addr_ok", data_addr_ok, 0);
         chk("bp_m_req", m_req, 1);
         chk("bp_wdata", m_wdata, 32'hDEADBEEF);
         advance();
      end
      m_addr_ok = 1;
      sample();
      chk("bp_addr_ok4", data_addr_ok, 1);
      advance();
      finish_txn();

      // Re-arbitration with last grant = data: selection stays inst
      inst_req = 1; inst_addr = 32'h400;
      step();
      data_req = 1; data_addr = 32'h500;
      sample();
      chk("rearb_keep", m_addr, 32'h400);
      advance();
      m_addr_ok = 1;
      sample();
      chk("rearb_keep_ok", inst_addr_ok, 1);
      advance();
      finish_txn();

      // Re-arbitration with last grant = inst: selection switches to data
      inst_req = 1; inst_addr = 32'h400;
      step();
      data_req = 1; data_addr = 32'h500;
      sample();
      chk("rearb_switch", m_addr, 32'h500);
      advance();
      m_addr_ok = 1;
      step();
      finish_txn();

      // Spurious m_data_ok in IDLE
      m_data_ok = 1;
      sample();
      chk("spur_i", inst_data_ok, 0);
      chk("spur_d", data_data_ok, 0);
      advance();
      clr();

      // Reset while WAIT_D, then a late m_data_ok
      data_req = 1; data_addr = 32'h600; m_addr_ok = 1;
      step();
      clr();
      rst = 0; model_reset();
      step();
      rst = 1;
      m_data_ok = 1;
      sample();
      chk("late_data_ok", data_data_ok, 0);
      advance();
      clr();

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         inst_req   = ($urandom_range(0, 2) != 0);
         data_req   = ($urandom_range(0, 2) != 0);
         inst_wr    = $urandom_range(0, 1);
         data_wr    = $urandom_range(0, 1);
         inst_size  = 2'($urandom_range(0, 3));
         data_size  = 2'($urandom_range(0, 3));
         inst_addr  = $urandom;
         data_addr  = $urandom;
         inst_wdata = $urandom;
         data_wdata = $urandom;
         m_addr_ok  = ($urandom_range(0, 2) != 0);
         m_data_ok  = ($urandom_range(0, 2) != 0);
         m_rdata    = $urandom;
         if ($urandom_range(0, 59) == 0) begin
            rst = 0;
            model_reset();
         end else begin
            rst = 1;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
